game_sequencer: RTL and testbench

Top-level game flow controller for Bumpy. It sequences the menu, level-load, play, died, level-won, game-over and victory phases, and owns the lives and level counters. It holds the gameplay logic in reset outside the PLAY phase. It drives one-hot screen selects for the drawing mux and times each transition screen with the one_sec strobe.

---
 rtl/game_sequencer.sv | 126 ++++++++++++
 tb/tb_game_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Bumpy top-level game flow: menu, level load, play, transition screens,
// plus the lives and level counters and the gameplay reset.
module game_sequencer #(
  parameter int unsigned LIVES_INIT = 3,
  parameter int unsigned NUM_LEVELS = 4,
  parameter int unsigned SCREEN_SEC = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_sec,
  input  logic       start_key,
  input  logic       bumpy_died,
  input  logic       level_comp,
  output logic       menu_screen,
  output logic       play_active,
  output logic       died_screen,
  output logic       win_screen,
  output logic       over_screen,
  output logic       victory_screen,
  output logic       play_rst,
  output logic [2:0] lvl,
  output logic [2:0] lives,
  output logic [3:0] sec_left
);

  typedef enum logic [2:0] {
    S_MENU, S_LOAD, S_PLAY, S_DIED, S_WIN, S_OVER, S_VICTORY
  } state_t;

  state_t     state, state_nx;
  logic [3:0] timer;
  logic       start_q;
  logic       start_edge;
  logic       in_screen;
  logic       expire;
  logic [2:0] lvl_nx;
  logic [2:0] lives_nx;

  assign start_edge = start_key & ~start_q;

  // Screen-state qualifiers shared by the timer and the next-state logic.
  always_comb begin
    in_screen = (state == S_DIED) || (state == S_WIN) ||
                (state == S_OVER) || (state == S_VICTORY);
    expire    = in_screen && one_sec && (timer == 4'(SCREEN_SEC - 1));
  end

  // Next-state, level and lives update.
  always_comb begin
    state_nx = state;
    lvl_nx   = lvl;
    lives_nx = lives;
    case (state)
      S_MENU: if (start_edge) begin
        state_nx = S_LOAD;
        lvl_nx   = '0;
        lives_nx = 3'(LIVES_INIT);
      end
      S_LOAD: state_nx = S_PLAY;
      S_PLAY: begin
        if (bumpy_died) begin
          state_nx = S_DIED;
          lives_nx = (lives == '0) ? '0 : lives - 3'd1;
        end else if (level_comp) begin
          state_nx = (lvl == 3'(NUM_LEVELS - 1)) ? S_VICTORY : S_WIN;
        end
      end
      S_DIED: if (expire) state_nx = (lives == '0) ? S_OVER : S_LOAD;
      S_WIN: if (expire) begin
        state_nx = S_LOAD;
        lvl_nx   = lvl + 3'd1;
      end
      S_OVER, S_VICTORY: if (expire) state_nx = S_MENU;
      default: state_nx = S_MENU;
    endcase
  end

  // State, counters, start-key history and screen timer.
  // Any state change clears the timer, which covers both screen entry and expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_MENU;
      lvl     <= '0;
      lives   <= 3'(LIVES_INIT);
      timer   <= '0;
      start_q <= 1'b1;
    end else begin
      state   <= state_nx;
      lvl     <= lvl_nx;
      lives   <= lives_nx;
      start_q <= start_key;
      if (state_nx != state)
        timer <= '0;
      else if (in_screen && one_sec)
        timer <= timer + 4'd1;
    end
  end

  // Registered one-hot screen selects, loaded from the next state so they track the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      menu_screen    <= 1'b1;
      play_active    <= 1'b0;
      died_screen    <= 1'b0;
      win_screen     <= 1'b0;
      over_screen    <= 1'b0;
      victory_screen <= 1'b0;
      play_rst       <= 1'b1;
    end else begin
      menu_screen    <= (state_nx == S_MENU);
      play_active    <= (state_nx == S_PLAY);
      died_screen    <= (state_nx == S_DIED);
      win_screen     <= (state_nx == S_WIN);
      over_screen    <= (state_nx == S_OVER);
      victory_screen <= (state_nx == S_VICTORY);
      play_rst       <= (state_nx != S_PLAY);
    end
  end

  // Seconds remaining on a transition screen.
  always_comb begin
    sec_left = '0;
    if (in_screen) sec_left = 4'(SCREEN_SEC) - timer;
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed scenarios followed by random
// stimulus, all compared every cycle against a phase/countdown reference model.
module tb_game_sequencer;

  localparam int LI = 3;
  localparam int NL = 4;
  localparam int SS = 3;

  logic       clk = 1'b0;
  logic       reset, one_sec, start_key, bumpy_died, level_comp;
  logic       menu_screen, play_active, died_screen, win_screen;
  logic       over_screen, victory_screen, play_rst;
  logic [2:0] lvl, lives;
  logic [3:0] sec_left;

  int checks = 0;
  int errors = 0;
  int os_cnt = 0;

  // reference model: phase name, counters, and a countdown of seconds left
  string m_phase = "MENU";
  int    m_lvl = 0, m_lives = LI, m_remain = 0;
  bit    m_prev_key = 1'b1;

  game_sequencer #(.LIVES_INIT(LI), .NUM_LEVELS(NL), .SCREEN_SEC(SS)) dut (
    .clk(clk), .reset(reset), .one_sec(one_sec), .start_key(start_key),
    .bumpy_died(bumpy_died), .level_comp(level_comp),
    .menu_screen(menu_screen), .play_active(play_active),
    .died_screen(died_screen), .win_screen(win_screen),
    .over_screen(over_screen), .victory_screen(victory_screen),
    .play_rst(play_rst), .lvl(lvl), .lives(lives), .sec_left(sec_left)
  );

  always #5 clk = ~clk;

  function automatic bit is_screen(input string p);
    return (p == "DIED") || (p == "WIN") || (p == "OVER") || (p == "VICTORY");
  endfunction

  task automatic enter_screen(input string p);
    m_phase  = p;
    m_remain = SS;
  endtask

  // advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    bit edge_k;
    if (reset) begin
      m_phase = "MENU"; m_lvl = 0; m_lives = LI; m_remain = 0; m_prev_key = 1'b1;
      return;
    end
    edge_k = start_key && !m_prev_key;
    m_prev_key = start_key;
    if (m_phase == "MENU") begin
      if (edge_k) begin m_phase = "LOAD"; m_lvl = 0; m_lives = LI; end
    end else if (m_phase == "LOAD") begin
      m_phase = "PLAY";
    end else if (m_phase == "PLAY") begin
      if (bumpy_died) begin
        if (m_lives > 0) m_lives--;
        enter_screen("DIED");
      end else if (level_comp) begin
        enter_screen(m_lvl == NL - 1 ? "VICTORY" : "WIN");
      end
    end else if (one_sec) begin
      m_remain--;
      if (m_remain == 0) begin
        if (m_phase == "DIED") begin
          if (m_lives == 0) enter_screen("OVER");
          else m_phase = "LOAD";
        end else if (m_phase == "WIN") begin
          m_lvl++;
          m_phase = "LOAD";
        end else begin
          m_phase = "MENU";
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [16:0] obs, exp;
    obs = {menu_screen, play_active, died_screen, win_screen, over_screen,
           victory_screen, play_rst, lvl, lives, sec_left};
    exp = {m_phase == "MENU", m_phase == "PLAY", m_phase == "DIED",
           m_phase == "WIN", m_phase == "OVER", m_phase == "VICTORY",
           m_phase != "PLAY", 3'(m_lvl), 3'(m_lives),
           is_screen(m_phase) ? 4'(m_remain) : 4'd0};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s phase=%s observed=%h expected=%h", tag, m_phase, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  // one cycle with one_sec pulsing every 10th cycle
  task automatic tick_os(input string tag);
    one_sec = (os_cnt == 9);
    os_cnt  = (os_cnt + 1) % 10;
    tick(tag);
    one_sec = 1'b0;
  endtask

  task automatic run_until(input string p, input string tag);
    int n = 0;
    while (m_phase != p && n < 200) begin tick_os(tag); n++; end
    if (m_phase != p) begin
      errors++;
      $error("FAIL %s timeout waiting for %s, model in %s", tag, p, m_phase);
    end
  endtask

  task automatic start_game(input string tag);
    start_key = 1'b0; tick(tag);
    start_key = 1'b1; tick(tag);
    start_key = 1'b0; tick(tag);
  endtask

  initial begin
    reset = 1'b1; one_sec = 1'b0; start_key = 1'b1;
    bumpy_died = 1'b0; level_comp = 1'b0;

    // 1: held start key across reset release must not start a game
    repeat (3) tick("reset");
    chk("reset_menu", menu_screen, 1);
    chk("reset_play_rst", play_rst, 1);
    chk("reset_lives", lives, LI);
    reset = 1'b0;
    repeat (5) tick("held_key");
    chk("held_key_menu", menu_screen, 1);
    start_key = 1'b0; repeat (2) tick("release");
    start_key = 1'b1; tick("press");
    chk("load_play_rst", play_rst, 1);
    chk("load_screens", {menu_screen, play_active, died_screen, win_screen,
                         over_screen, victory_screen}, 0);
    tick("to_play");
    start_key = 1'b0;
    chk("play_active", play_active, 1);
    chk("play_rst_low", play_rst, 0);
    chk("play_lvl0", lvl, 0);
    chk("play_lives", lives, LI);

    // 2: level won screen, countdown, next level
    os_cnt = 0;
    level_comp = 1'b1; tick("comp"); level_comp = 1'b0;
    chk("win_screen", win_screen, 1);
    chk("win_sec3", sec_left, SS);
    run_until("PLAY", "win_wait");
    chk("lvl1", lvl, 1);

    // 3: three deaths lead to game over, then menu
    for (int k = 0; k < 3; k++) begin
      bumpy_died = 1'b1; tick("die"); bumpy_died = 1'b0;
      chk("lives_after_death", lives, LI - 1 - k);
      chk("died_screen", died_screen, 1);
      if (k < 2) run_until("PLAY", "died_wait");
      else run_until("OVER", "over_wait");
    end
    chk("over_screen", over_screen, 1);
    run_until("MENU", "over_exit");
    chk("menu_after_over", menu_screen, 1);

    // held death event costs exactly one life
    start_game("start2");
    run_until("PLAY", "play2");
    bumpy_died = 1'b1;
    repeat (50) tick("hold_died");
    bumpy_died = 1'b0;
    chk("hold_one_life", lives, LI - 1);
    run_until("PLAY", "back_play");

    // 4: clear levels up to the last, then victory
    for (int k = 0; k < NL - 1; k++) begin
      level_comp = 1'b1; tick("comp_lv"); level_comp = 1'b0;
      run_until("PLAY", "next_lv");
    end
    chk("lvl_last", lvl, NL - 1);
    level_comp = 1'b1; tick("comp_last"); level_comp = 1'b0;
    chk("victory", victory_screen, 1);
    chk("victory_lvl", lvl, NL - 1);
    run_until("MENU", "vic_exit");

    start_game("start3");
    run_until("PLAY", "play3");
    bumpy_died = 1'b1; level_comp = 1'b1; tick("both"); 
    bumpy_died = 1'b0; level_comp = 1'b0;
    chk("both_died", died_screen, 1);
    chk("both_lives", lives, LI - 1);
    chk("both_lvl", lvl, 0);

    // 5: reset in the middle of the win screen
    run_until("PLAY", "play4");
    level_comp = 1'b1; tick("comp5"); level_comp = 1'b0;
    while (m_phase == "WIN" && m_remain != SS - 1) tick_os("win_t1");
    reset = 1'b1; tick("mid_reset"); reset = 1'b0;
    chk("mr_menu", menu_screen, 1);
    chk("mr_lvl", lvl, 0);
    chk("mr_lives", lives, LI);
    chk("mr_sec", sec_left, 0);
    chk("mr_rst", play_rst, 1);

    // 6: events ignored outside play
    bumpy_died = 1'b1; level_comp = 1'b1; repeat (3) tick("menu_ev");
    bumpy_died = 1'b0; level_comp = 1'b0;
    chk("menu_ev_state", menu_screen, 1);
    start_game("start6");
    run_until("PLAY", "play6");
    bumpy_died = 1'b1; tick("die6"); bumpy_died = 1'b0;
    tick("died6");
    bumpy_died = 1'b1; level_comp = 1'b1; repeat (3) tick("died_ev");
    bumpy_died = 1'b0; level_comp = 1'b0;
    chk("died_ev_lives", lives, LI - 1);
    chk("died_ev_state", died_screen, 1);
    run_until("PLAY", "play6b");
    level_comp = 1'b1; tick("comp6"); level_comp = 1'b0;
    bumpy_died = 1'b1; level_comp = 1'b1; repeat (3) tick("win_ev");
    bumpy_died = 1'b0; level_comp = 1'b0;
    chk("win_ev_state", win_screen, 1);
    chk("win_ev_lvl", lvl, 0);
    chk("win_ev_lives", lives, LI - 1);

    // random stimulus
    for (int i = 0; i < 4000; i++) begin
      reset      = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 7) == 0) start_key = ~start_key;
      one_sec    = ($urandom_range(0, 5) == 0);
      bumpy_died = ($urandom_range(0, 19) == 0);
      level_comp = ($urandom_range(0, 14) == 0);
      tick("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
